slon_led_seq: RTL and testbench



---
 rtl/slon_pkg.sv | 31 +++
 rtl/slon_led_seq_if.sv | 25 ++
 rtl/slon_tick_gen.sv | 37 +++
 rtl/slon_led_seq.sv | 88 ++++++++
 tb/tb_slon_led_seq.sv | 139 +++++++++++++
 5 files changed

// File: rtl/slon_pkg.sv
// Shared types and constants for the slon board LED sequencer.
// Pattern modes, bounce direction and per-mode reload values.
package slon_pkg;

    typedef enum logic [1:0] {
        LED_STATIC,
        LED_COUNT,
        LED_WALK,
        LED_BOUNCE
    } led_mode_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } led_dir_t;

    localparam logic [3:0] LED_STATIC_PAT  = 4'b1010;
    localparam logic [3:0] LED_ONEHOT_INIT = 4'b0001;

    function automatic logic [3:0] mode_init(led_mode_t m);
        logic [3:0] v;
        unique case (m)
            LED_STATIC: v = LED_STATIC_PAT;
            LED_COUNT:  v = 4'b0000;
            LED_WALK:   v = LED_ONEHOT_INIT;
            LED_BOUNCE: v = LED_ONEHOT_INIT;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/slon_led_seq_if.sv
// Control/pattern bundle between the LED sequencer and its driver.
// The sequencer is the slave; the driver sets en/mode and reads led/stepTick.
interface slon_led_seq_if;
    import slon_pkg::*;

    logic      en;
    led_mode_t mode;
    logic [3:0] led;
    logic      stepTick;

    modport master (
        output en,
        output mode,
        input  led,
        input  stepTick
    );

    modport slave (
        input  en,
        input  mode,
        output led,
        output stepTick
    );

endinterface

// File: rtl/slon_tick_gen.sv
// Enable-gated prescaler producing a one-cycle tick every TICK_DIV cycles.
// Counter freezes while en is low so a paused step resumes where it left off.
module slon_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/slon_led_seq.sv
// LED pattern sequencer: static, binary count, walking one, ping-pong.
// A mode change is taken only on a tick and reloads instead of stepping.
module slon_led_seq
    import slon_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic           clk,
    input  logic           rst_n,
    slon_led_seq_if.slave  bus
);

    logic      tick;
    logic [3:0] led_q, led_d;
    led_mode_t mode_q, mode_d;
    led_dir_t  dir_q, dir_d;
    logic      step_q;
    logic [3:0] shl, shr;

    slon_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .tick  (tick)
    );

    assign shl = {led_q[2:0], 1'b0};
    assign shr = {1'b0, led_q[3:1]};

    always_comb begin
        led_d  = led_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (tick) begin
            if (bus.mode != mode_q) begin
                mode_d = bus.mode;
                led_d  = mode_init(bus.mode);
                dir_d  = DIR_UP;
            end else begin
                unique case (mode_q)
                    LED_STATIC: led_d = LED_STATIC_PAT;
                    LED_COUNT:  led_d = led_q + 4'd1;
                    LED_WALK: begin
                        if (!$onehot(led_q)) begin
                            led_d = LED_ONEHOT_INIT;
                            dir_d = DIR_UP;
                        end else begin
                            led_d = {led_q[2:0], led_q[3]};
                        end
                    end
                    LED_BOUNCE: begin
                        // direction flips on reaching either end, not on leaving it
                        if (!$onehot(led_q)) begin
                            led_d = LED_ONEHOT_INIT;
                            dir_d = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            led_d = shl;
                            if (shl == 4'b1000) dir_d = DIR_DOWN;
                        end else begin
                            led_d = shr;
                            if (shr == 4'b0001) dir_d = DIR_UP;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= LED_STATIC_PAT;
            mode_q <= LED_STATIC;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            step_q <= tick;
        end
    end

    assign bus.led      = led_q;
    assign bus.stepTick = step_q;

endmodule

// File: tb/tb_slon_led_seq.sv
// Directed bench for slon_led_seq with TICK_DIV=4.
// Covers all modes, mode-switch timing, en pause and async reset.
module tb_slon_led_seq;
    import slon_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    slon_led_seq_if bus ();

    slon_led_seq #(
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] bseq [7];
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                 4'b0010, 4'b0001, 4'b0010};
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.mode = LED_STATIC;
        step(2);
        chk("rst_led", bus.led, 4'b1010);
        chk("rst_step", 4'(bus.stepTick), 4'd0);

        rst_n = 1'b1;
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(3);
            chk("static_idle_step", 4'(bus.stepTick), 4'd0);
            chk("static_idle_led", bus.led, 4'b1010);
            step(1);
            chk("static_tick_step", 4'(bus.stepTick), 4'd1);
            chk("static_tick_led", bus.led, 4'b1010);
        end

        bus.mode = LED_COUNT;
        step(4);
        chk("count_reload", bus.led, 4'b0000);
        chk("count_reload_step", 4'(bus.stepTick), 4'd1);
        for (int i = 1; i <= 16; i++) begin
            step(4);
            chk("count_step", bus.led, 4'(i));
        end

        bus.mode = LED_BOUNCE;
        step(4);
        chk("bounce_reload", bus.led, 4'b0001);
        for (int i = 0; i < 7; i++) begin
            step(4);
            chk("bounce_seq", bus.led, bseq[i]);
        end

        bus.mode = LED_WALK;
        step(4);
        chk("walk_reload", bus.led, 4'b0001);
        step(4);
        chk("walk_step", bus.led, 4'b0010);
        step(2);
        bus.mode = LED_COUNT;
        chk("sw_hold0", bus.led, 4'b0010);
        step(1);
        chk("sw_hold1", bus.led, 4'b0010);
        step(1);
        chk("sw_count", bus.led, 4'b0000);
        chk("sw_count_step", 4'(bus.stepTick), 4'd1);
        step(1);
        bus.mode = LED_WALK;
        chk("sw_hold2", bus.led, 4'b0000);
        step(2);
        chk("sw_hold3", bus.led, 4'b0000);
        step(1);
        chk("sw_walk", bus.led, 4'b0001);

        step(2);
        bus.en = 1'b0;
        step(10);
        chk("pause_led", bus.led, 4'b0001);
        chk("pause_step", 4'(bus.stepTick), 4'd0);
        bus.en = 1'b1;
        step(1);
        chk("resume_hold", bus.led, 4'b0001);
        step(1);
        chk("resume_led", bus.led, 4'b0010);
        chk("resume_step", 4'(bus.stepTick), 4'd1);
        step(3);
        chk("resume_noextra", bus.led, 4'b0010);
        chk("resume_nostep", 4'(bus.stepTick), 4'd0);
        step(1);
        chk("resume_next", bus.led, 4'b0100);

        bus.mode = LED_COUNT;
        step(4);
        chk("rc_reload", bus.led, 4'b0000);
        step(24);
        chk("rc_at6", bus.led, 4'b0110);
        rst_n = 1'b0;
        #1;
        chk("arst_led", bus.led, 4'b1010);
        chk("arst_step", 4'(bus.stepTick), 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3);
        chk("post_rst_hold", bus.led, 4'b1010);
        step(1);
        chk("post_rst_reload", bus.led, 4'b0000);
        chk("post_rst_step", 4'(bus.stepTick), 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
